jpeg_bitstream_writer: RTL and testbench

//  Entropy-coded-segment byte packer for the JPEG encoder path; it is the transmit-side counterpart of the decoder's bitstream reader.

---
 rtl/jpeg_enc_pkg.sv | 15 +
 rtl/jpeg_bitstream_writer.sv | 111 +++++++++++
 tb/tb_jpeg_bitstream_writer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_enc_pkg.sv
// Shared JPEG encoder constants and the bitstream writer state encoding.
package jpeg_enc_pkg;

   localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
   localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
   localparam int         CODE_LEN_W         = 5;

   typedef enum logic [1:0] {
      ST_ACTIVE,
      ST_PAD,
      ST_DRAIN,
      ST_DONE
   } writer_state_t;

endpackage

// File: rtl/jpeg_bitstream_writer.sv
// Packs right-aligned variable-length codes MSB-first into bytes, stuffing 0x00
// after every 0xFF, with a flush sequence that pads the last byte with 1s.
module jpeg_bitstream_writer
   import jpeg_enc_pkg::*;
#(
   parameter int MAX_CODE_LEN = 16,
   parameter int ACC_W        = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [MAX_CODE_LEN-1:0] code_in,
   input  logic [CODE_LEN_W-1:0]   code_len,
   input  logic                    code_valid,
   output logic                    code_ready,
   input  logic                    flush,
   output logic                    flush_done,
   output logic [7:0]              byte_out,
   output logic                    byte_valid,
   input  logic                    byte_ready
);

   localparam int CNT_W = $clog2(ACC_W + 1);

   writer_state_t        state;
   logic [ACC_W-1:0]     acc;
   logic [CNT_W-1:0]     bit_cnt;
   logic                 stuff;

   logic [CODE_LEN_W-1:0] len_c;
   logic [ACC_W-1:0]      code_ext;
   logic [2:0]            pad_len;
   logic                  accept;
   logic                  out_free;
   logic                  load_data;
   logic [ACC_W-1:0]      acc_nx;
   logic [CNT_W-1:0]      cnt_nx;
   logic [7:0]            data_byte;

   always_comb begin
      len_c      = (code_len > CODE_LEN_W'(MAX_CODE_LEN)) ? CODE_LEN_W'(MAX_CODE_LEN) : code_len;
      code_ext   = ACC_W'(code_in) & ~({ACC_W{1'b1}} << len_c);
      code_ready = !rst && (state == ST_ACTIVE) &&
                   (({1'b0, bit_cnt} + (CNT_W+1)'(MAX_CODE_LEN)) <= (CNT_W+1)'(ACC_W));
      accept     = code_valid && code_ready;
      pad_len    = 3'(~bit_cnt[2:0] + 3'd1);

      // Byte extraction sees this cycle's append so a byte appears one cycle after its last bit.
      acc_nx = acc;
      cnt_nx = bit_cnt;
      if (accept) begin
         acc_nx = (acc << len_c) | code_ext;
         cnt_nx = bit_cnt + CNT_W'(len_c);
      end else if (state == ST_PAD) begin
         acc_nx = (acc << pad_len) | ~({ACC_W{1'b1}} << pad_len);
         cnt_nx = bit_cnt + CNT_W'(pad_len);
      end

      out_free  = !byte_valid || byte_ready;
      data_byte = 8'(acc_nx >> (cnt_nx - CNT_W'(8)));
      load_data = out_free && !stuff && (cnt_nx >= CNT_W'(8));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_ACTIVE;
         acc        <= '0;
         bit_cnt    <= '0;
         stuff      <= 1'b0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         acc        <= acc_nx;
         bit_cnt    <= cnt_nx;
         flush_done <= 1'b0;

         if (out_free) begin
            if (stuff) begin
               byte_out   <= JPEG_STUFF_BYTE;
               byte_valid <= 1'b1;
               stuff      <= 1'b0;
            end else if (load_data) begin
               byte_out   <= data_byte;
               byte_valid <= 1'b1;
               bit_cnt    <= cnt_nx - CNT_W'(8);
               stuff      <= (data_byte == JPEG_MARKER_PREFIX);
            end else begin
               byte_valid <= 1'b0;
            end
         end

         case (state)
            ST_ACTIVE: if (flush) state <= ST_PAD;
            ST_PAD:    state <= ST_DRAIN;
            ST_DRAIN: begin
               if (bit_cnt == '0 && !stuff && !byte_valid) begin
                  state      <= ST_DONE;
                  flush_done <= 1'b1;
               end
            end
            ST_DONE: begin
               state   <= ST_ACTIVE;
               acc     <= '0;
               bit_cnt <= '0;
            end
            default: state <= ST_ACTIVE;
         endcase
      end
   end

endmodule

// File: tb/tb_jpeg_bitstream_writer.sv
// Directed scoreboard bench for jpeg_bitstream_writer: expected bytes and flush
// markers are queued by the stimulus and popped by an independent monitor.
module tb_jpeg_bitstream_writer;

   localparam logic [8:0] FLUSH_MARK = 9'h100;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] code_in;
   logic [4:0]  code_len;
   logic        code_valid;
   logic        code_ready;
   logic        flush;
   logic        flush_done;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;

   int passed = 0;
   int total  = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   jpeg_bitstream_writer #(.MAX_CODE_LEN(16), .ACC_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .code_in    (code_in),
      .code_len   (code_len),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .flush      (flush),
      .flush_done (flush_done),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: a handshake happens at the next rising edge when valid & ready hold here.
   always @(negedge clk) begin
      if (!rst) begin
         if (byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_byte: got %0h expected none", byte_out);
            end else begin
               check("byte", {23'd0, 1'b0, byte_out}, {23'd0, exp_q.pop_front()});
            end
         end
         if (flush_done) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_flush_done: got 1 expected none");
            end else begin
               check("flush_done_order", {23'd0, FLUSH_MARK}, {23'd0, exp_q.pop_front()});
            end
         end
      end
   end

   // All tasks start and end at posedge+#1.
   task automatic send_code(input logic [15:0] c, input logic [4:0] l);
      bit got = 0;
      code_in    = c;
      code_len   = l;
      code_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (code_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) check("code_accept_timeout", {31'd0, code_ready}, 32'd1);
      @(posedge clk); #1;
      code_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; code_in = '0; code_len = '0; code_valid = 1'b0;
      flush = 1'b0; byte_ready = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("reset_byte_valid", {31'd0, byte_valid}, 32'd0);
      check("reset_code_ready", {31'd0, code_ready}, 32'd0);
      check("reset_flush_done", {31'd0, flush_done}, 32'd0);
      check("reset_byte_out", {24'd0, byte_out}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_code_ready", {31'd0, code_ready}, 32'd1);
      @(posedge clk); #1;

      // 101 + 11111 -> 0xBF
      exp_q.push_back(9'h0BF);
      send_code(16'h0005, 5'd3);
      send_code(16'h001F, 5'd5);
      wait_drain();

      // 0xFF is stuffed
      exp_q.push_back(9'h0FF);
      exp_q.push_back(9'h000);
      send_code(16'h00FF, 5'd8);
      wait_drain();

      // single 0 bit, flush pads to 0x7F; next code starts a fresh byte
      exp_q.push_back(9'h07F);
      exp_q.push_back(FLUSH_MARK);
      send_code(16'h0000, 5'd1);
      do_flush();
      wait_drain();
      exp_q.push_back(9'h03C);
      send_code(16'h003C, 5'd8);
      wait_drain();

      // 1111 + padding 1111 -> FF 00
      exp_q.push_back(9'h0FF);
      exp_q.push_back(9'h000);
      exp_q.push_back(FLUSH_MARK);
      send_code(16'h000F, 5'd4);
      do_flush();
      wait_drain();

      // flush with nothing pending: flush_done only
      exp_q.push_back(FLUSH_MARK);
      do_flush();
      wait_drain();

      // zero-length code is a no-op; oversize length clamps to 16
      exp_q.push_back(9'h001);
      exp_q.push_back(9'h002);
      send_code(16'hFFFF, 5'd0);
      send_code(16'h0102, 5'd20);
      wait_drain();

      // backpressure: accumulator fills, order preserved
      byte_ready = 1'b0;
      exp_q.push_back(9'h012); exp_q.push_back(9'h034);
      exp_q.push_back(9'h056); exp_q.push_back(9'h078);
      exp_q.push_back(9'h09A); exp_q.push_back(9'h0BC);
      fork
         begin
            send_code(16'h1234, 5'd16);
            send_code(16'h5678, 5'd16);
            send_code(16'h9ABC, 5'd16);
         end
         begin
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (i == 12) begin
                  check("bp_code_ready_low", {31'd0, code_ready}, 32'd0);
                  check("bp_byte_valid", {31'd0, byte_valid}, 32'd1);
                  check("bp_byte_out_early", {24'd0, byte_out}, 32'h12);
               end
               if (i == 19) check("bp_byte_out_late", {24'd0, byte_out}, 32'h12);
            end
            @(posedge clk); #1;
            byte_ready = 1'b1;
         end
      join
      wait_drain();

      // reset mid-stream discards held byte and 5 pending bits
      byte_ready = 1'b0;
      send_code(16'h1ABC, 5'd13);
      @(negedge clk);
      check("pre_reset_byte_valid", {31'd0, byte_valid}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_cycle_code_ready", {31'd0, code_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_byte_valid", {31'd0, byte_valid}, 32'd0);
      check("post_reset_byte_out", {24'd0, byte_out}, 32'd0);
      @(posedge clk); #1;
      byte_ready = 1'b1;
      exp_q.push_back(9'h0A5);
      send_code(16'h00A5, 5'd8);
      wait_drain();
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
